// File: rtl/nasti_pkg.sv
// Shared types for the NASTI multiplexer: FSM state encodings, port count
// and the one-hot to index helper used after round-robin arbitration.
package nasti_pkg;

  localparam int NUM_PORTS = 8;
  localparam int SEL_W     = $clog2(NUM_PORTS);
  // len(8) + size(3) + burst(2) + lock(1) + cache(4) + prot(3) + qos(4) + region(4)
  localparam int AX_FIXED_W = 29;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NUM_PORTS-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (oh[i]) idx = idx | SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arbiter_rr.sv
// Round-robin arbiter: combinational one-hot grant from the registered
// priority pointer; the pointer moves past the winner only when enabled.
module arbiter_rr #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_nxt_ptr;
  logic [IW-1:0] w_idx;

  // Scan from lowest priority to highest so the last hit is the winner.
  always_comb begin
    o_gnt     = '0;
    w_nxt_ptr = r_ptr;
    w_idx     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_idx = IW'((int'(r_ptr) + i) % N);
      if (i_req[w_idx]) begin
        o_gnt        = '0;
        o_gnt[w_idx] = 1'b1;
        w_nxt_ptr    = IW'((int'(r_ptr) + i + 1) % N);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_en && (|i_req)) begin
      r_ptr <= w_nxt_ptr;
    end
  end

endmodule

// File: rtl/nasti_mux.sv
// Eight-to-one NASTI mux with independent round-robin write and read FSMs,
// one outstanding transaction per direction; grant registered, beats pass through.
module nasti_mux
  import nasti_pkg::*;
#(
  parameter int   ID_WIDTH   = 1,
  parameter int   ADDR_WIDTH = 8,
  parameter int   DATA_WIDTH = 8,
  parameter int   USER_WIDTH = 1,
  parameter logic [NUM_PORTS-1:0] PORT_EN = 8'hFF,
  localparam int  AX_W = ID_WIDTH + ADDR_WIDTH + AX_FIXED_W + USER_WIDTH,
  localparam int  W_W  = DATA_WIDTH + DATA_WIDTH / 8 + USER_WIDTH,
  localparam int  B_W  = ID_WIDTH + 2 + USER_WIDTH,
  localparam int  R_W  = ID_WIDTH + DATA_WIDTH + 2 + USER_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             i_s_aw_vld,
  input  logic [NUM_PORTS-1:0][AX_W-1:0]   i_s_aw_dat,
  output logic [NUM_PORTS-1:0]             o_s_aw_rdy,
  input  logic [NUM_PORTS-1:0]             i_s_w_vld,
  input  logic [NUM_PORTS-1:0][W_W-1:0]    i_s_w_dat,
  input  logic [NUM_PORTS-1:0]             i_s_w_last,
  output logic [NUM_PORTS-1:0]             o_s_w_rdy,
  output logic [NUM_PORTS-1:0]             o_s_b_vld,
  output logic [NUM_PORTS-1:0][B_W-1:0]    o_s_b_dat,
  input  logic [NUM_PORTS-1:0]             i_s_b_rdy,
  input  logic [NUM_PORTS-1:0]             i_s_ar_vld,
  input  logic [NUM_PORTS-1:0][AX_W-1:0]   i_s_ar_dat,
  output logic [NUM_PORTS-1:0]             o_s_ar_rdy,
  output logic [NUM_PORTS-1:0]             o_s_r_vld,
  output logic [NUM_PORTS-1:0][R_W-1:0]    o_s_r_dat,
  output logic [NUM_PORTS-1:0]             o_s_r_last,
  input  logic [NUM_PORTS-1:0]             i_s_r_rdy,
  output logic                             o_m_aw_vld,
  output logic [AX_W-1:0]                  o_m_aw_dat,
  input  logic                             i_m_aw_rdy,
  output logic                             o_m_w_vld,
  output logic [W_W-1:0]                   o_m_w_dat,
  output logic                             o_m_w_last,
  input  logic                             i_m_w_rdy,
  input  logic                             i_m_b_vld,
  input  logic [B_W-1:0]                   i_m_b_dat,
  output logic                             o_m_b_rdy,
  output logic                             o_m_ar_vld,
  output logic [AX_W-1:0]                  o_m_ar_dat,
  input  logic                             i_m_ar_rdy,
  input  logic                             i_m_r_vld,
  input  logic [R_W-1:0]                   i_m_r_dat,
  input  logic                             i_m_r_last,
  output logic                             o_m_r_rdy
);

  w_state_t             r_wstate, w_wstate_nxt;
  r_state_t             r_rstate, w_rstate_nxt;
  logic [SEL_W-1:0]     r_wsel, w_wsel_nxt;
  logic [SEL_W-1:0]     r_rsel, w_rsel_nxt;
  logic [NUM_PORTS-1:0] w_wreq, w_wgnt, w_rreq, w_rgnt;

  assign w_wreq = i_s_aw_vld & PORT_EN;
  assign w_rreq = i_s_ar_vld & PORT_EN;

  arbiter_rr #(.N(NUM_PORTS)) u_warb (
    .clk   (clk),
    .rst   (rst),
    .i_en  (r_wstate == W_IDLE),
    .i_req (w_wreq),
    .o_gnt (w_wgnt)
  );

  arbiter_rr #(.N(NUM_PORTS)) u_rarb (
    .clk   (clk),
    .rst   (rst),
    .i_en  (r_rstate == R_IDLE),
    .i_req (w_rreq),
    .o_gnt (w_rgnt)
  );

  // Payloads are steered unconditionally; only valids and readys are gated.
  assign o_m_aw_dat = i_s_aw_dat[r_wsel];
  assign o_m_w_dat  = i_s_w_dat[r_wsel];
  assign o_m_w_last = i_s_w_last[r_wsel];
  assign o_m_ar_dat = i_s_ar_dat[r_rsel];
  assign o_s_b_dat  = {NUM_PORTS{i_m_b_dat}};
  assign o_s_r_dat  = {NUM_PORTS{i_m_r_dat}};
  assign o_s_r_last = {NUM_PORTS{i_m_r_last}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate <= W_IDLE;
      r_wsel   <= '0;
      r_rstate <= R_IDLE;
      r_rsel   <= '0;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_wsel   <= w_wsel_nxt;
      r_rstate <= w_rstate_nxt;
      r_rsel   <= w_rsel_nxt;
    end
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_wsel_nxt   = r_wsel;
    o_m_aw_vld   = 1'b0;
    o_s_aw_rdy   = '0;
    o_m_w_vld    = 1'b0;
    o_s_w_rdy    = '0;
    o_s_b_vld    = '0;
    o_m_b_rdy    = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (|w_wreq) begin
          w_wsel_nxt   = onehot_to_idx(w_wgnt);
          w_wstate_nxt = W_ADDR;
        end
      end
      W_ADDR: begin
        o_m_aw_vld         = i_s_aw_vld[r_wsel];
        o_s_aw_rdy[r_wsel] = i_m_aw_rdy;
        if (i_s_aw_vld[r_wsel] && i_m_aw_rdy) w_wstate_nxt = W_DATA;
      end
      W_DATA: begin
        o_m_w_vld         = i_s_w_vld[r_wsel];
        o_s_w_rdy[r_wsel] = i_m_w_rdy;
        if (i_s_w_vld[r_wsel] && i_m_w_rdy && i_s_w_last[r_wsel]) w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        o_s_b_vld[r_wsel] = i_m_b_vld;
        o_m_b_rdy         = i_s_b_rdy[r_wsel];
        if (i_m_b_vld && i_s_b_rdy[r_wsel]) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_rsel_nxt   = r_rsel;
    o_m_ar_vld   = 1'b0;
    o_s_ar_rdy   = '0;
    o_s_r_vld    = '0;
    o_m_r_rdy    = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (|w_rreq) begin
          w_rsel_nxt   = onehot_to_idx(w_rgnt);
          w_rstate_nxt = R_ADDR;
        end
      end
      R_ADDR: begin
        o_m_ar_vld         = i_s_ar_vld[r_rsel];
        o_s_ar_rdy[r_rsel] = i_m_ar_rdy;
        if (i_s_ar_vld[r_rsel] && i_m_ar_rdy) w_rstate_nxt = R_DATA;
      end
      R_DATA: begin
        o_s_r_vld[r_rsel] = i_m_r_vld;
        o_m_r_rdy         = i_s_r_rdy[r_rsel];
        if (i_m_r_vld && i_s_r_rdy[r_rsel] && i_m_r_last) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_nasti_mux.sv
// Directed bench for nasti_mux: arbitration order, burst forwarding, parallel
// read/write, reset mid-burst, W-before-AW hold-off and disabled ports.
module tb_nasti_mux;

  localparam int AX_W = 39;
  localparam int W_W  = 10;
  localparam int B_W  = 4;
  localparam int R_W  = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]           s_aw_vld, s_w_vld, s_w_last, s_b_rdy, s_ar_vld, s_r_rdy;
  logic [7:0][AX_W-1:0] s_aw_dat, s_ar_dat;
  logic [7:0][W_W-1:0]  s_w_dat;
  logic                 m_aw_rdy, m_w_rdy, m_b_vld, m_ar_rdy, m_r_vld, m_r_last;
  logic [B_W-1:0]       m_b_dat;
  logic [R_W-1:0]       m_r_dat;

  logic [7:0]           s_aw_rdy, s_w_rdy, s_b_vld, s_ar_rdy, s_r_vld, s_r_last;
  logic [7:0][B_W-1:0]  s_b_dat;
  logic [7:0][R_W-1:0]  s_r_dat;
  logic                 m_aw_vld, m_w_vld, m_w_last, m_b_rdy, m_ar_vld, m_r_rdy;
  logic [AX_W-1:0]      m_aw_dat, m_ar_dat;
  logic [W_W-1:0]       m_w_dat;

  logic [7:0]           e_s_aw_rdy, e_s_w_rdy, e_s_b_vld, e_s_ar_rdy, e_s_r_vld, e_s_r_last;
  logic [7:0][B_W-1:0]  e_s_b_dat;
  logic [7:0][R_W-1:0]  e_s_r_dat;
  logic                 e_m_aw_vld, e_m_w_vld, e_m_w_last, e_m_b_rdy, e_m_ar_vld, e_m_r_rdy;
  logic [AX_W-1:0]      e_m_aw_dat, e_m_ar_dat;
  logic [W_W-1:0]       e_m_w_dat;

  nasti_mux dut (
    .clk(clk), .rst(rst),
    .i_s_aw_vld(s_aw_vld), .i_s_aw_dat(s_aw_dat), .o_s_aw_rdy(s_aw_rdy),
    .i_s_w_vld(s_w_vld), .i_s_w_dat(s_w_dat), .i_s_w_last(s_w_last), .o_s_w_rdy(s_w_rdy),
    .o_s_b_vld(s_b_vld), .o_s_b_dat(s_b_dat), .i_s_b_rdy(s_b_rdy),
    .i_s_ar_vld(s_ar_vld), .i_s_ar_dat(s_ar_dat), .o_s_ar_rdy(s_ar_rdy),
    .o_s_r_vld(s_r_vld), .o_s_r_dat(s_r_dat), .o_s_r_last(s_r_last), .i_s_r_rdy(s_r_rdy),
    .o_m_aw_vld(m_aw_vld), .o_m_aw_dat(m_aw_dat), .i_m_aw_rdy(m_aw_rdy),
    .o_m_w_vld(m_w_vld), .o_m_w_dat(m_w_dat), .o_m_w_last(m_w_last), .i_m_w_rdy(m_w_rdy),
    .i_m_b_vld(m_b_vld), .i_m_b_dat(m_b_dat), .o_m_b_rdy(m_b_rdy),
    .o_m_ar_vld(m_ar_vld), .o_m_ar_dat(m_ar_dat), .i_m_ar_rdy(m_ar_rdy),
    .i_m_r_vld(m_r_vld), .i_m_r_dat(m_r_dat), .i_m_r_last(m_r_last), .o_m_r_rdy(m_r_rdy)
  );

  nasti_mux #(.PORT_EN(8'h0F)) dut_en (
    .clk(clk), .rst(rst),
    .i_s_aw_vld(s_aw_vld), .i_s_aw_dat(s_aw_dat), .o_s_aw_rdy(e_s_aw_rdy),
    .i_s_w_vld(s_w_vld), .i_s_w_dat(s_w_dat), .i_s_w_last(s_w_last), .o_s_w_rdy(e_s_w_rdy),
    .o_s_b_vld(e_s_b_vld), .o_s_b_dat(e_s_b_dat), .i_s_b_rdy(s_b_rdy),
    .i_s_ar_vld(s_ar_vld), .i_s_ar_dat(s_ar_dat), .o_s_ar_rdy(e_s_ar_rdy),
    .o_s_r_vld(e_s_r_vld), .o_s_r_dat(e_s_r_dat), .o_s_r_last(e_s_r_last), .i_s_r_rdy(s_r_rdy),
    .o_m_aw_vld(e_m_aw_vld), .o_m_aw_dat(e_m_aw_dat), .i_m_aw_rdy(m_aw_rdy),
    .o_m_w_vld(e_m_w_vld), .o_m_w_dat(e_m_w_dat), .o_m_w_last(e_m_w_last), .i_m_w_rdy(m_w_rdy),
    .i_m_b_vld(m_b_vld), .i_m_b_dat(m_b_dat), .o_m_b_rdy(e_m_b_rdy),
    .o_m_ar_vld(e_m_ar_vld), .o_m_ar_dat(e_m_ar_dat), .i_m_ar_rdy(m_ar_rdy),
    .i_m_r_vld(m_r_vld), .i_m_r_dat(m_r_dat), .i_m_r_last(m_r_last), .o_m_r_rdy(e_m_r_rdy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // {id, addr, len, size, burst=INCR, lock, cache, prot, qos, region, user}
  function automatic logic [AX_W-1:0] mk_ax(input logic [7:0] addr, input logic [7:0] len,
                                            input logic id);
    return {id, addr, len, 3'd0, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 1'b0};
  endfunction

  function automatic logic [W_W-1:0] mk_w(input logic [7:0] d);
    return {d, 1'b1, 1'b0};
  endfunction

  function automatic logic [R_W-1:0] mk_r(input logic [7:0] d);
    return {1'b0, d, 2'b00, 1'b0};
  endfunction

  int            order[6] = '{1, 4, 6, 1, 4, 6};
  logic [7:0]    rr_addr[8];
  logic [7:0]    rr_wd[8];
  int            g;

  initial begin
    rst = 1'b1;
    s_aw_vld = '0; s_w_vld = '0; s_w_last = '0; s_b_rdy = '0; s_ar_vld = '0; s_r_rdy = '0;
    s_aw_dat = '0; s_ar_dat = '0; s_w_dat = '0;
    m_aw_rdy = 1'b0; m_w_rdy = 1'b0; m_b_vld = 1'b0; m_ar_rdy = 1'b0;
    m_r_vld = 1'b0; m_r_last = 1'b0; m_b_dat = '0; m_r_dat = '0;
    for (int i = 0; i < 8; i++) begin
      rr_addr[i] = 8'h11 * 8'(i);
      rr_wd[i]   = 8'hA0 + 8'(i);
    end

    // Reset state
    #3;
    chk("rst_m_valids", {m_aw_vld, m_w_vld, m_ar_vld}, 3'b000);
    chk("rst_s_readys", {s_aw_rdy, s_w_rdy, s_ar_rdy}, 24'h0);
    chk("rst_s_rsp_vld", {s_b_vld, s_r_vld}, 16'h0);
    chk("rst_m_rsp_rdy", {m_b_rdy, m_r_rdy}, 2'b00);
    tick(); tick();
    rst = 1'b0;

    // Ports 1, 4, 6 writing continuously: round-robin order and turnaround
    m_aw_rdy = 1'b1; m_w_rdy = 1'b1; m_b_vld = 1'b1; m_b_dat = 4'h0;
    s_aw_vld = 8'h52; s_w_vld = 8'h52; s_w_last = 8'h52; s_b_rdy = 8'h52;
    for (int p = 0; p < 8; p++) begin
      s_aw_dat[p] = mk_ax(rr_addr[p], 8'd0, 1'b0);
      s_w_dat[p]  = mk_w(rr_wd[p]);
    end
    #1 chk("rr_idle_no_comb_path", m_aw_vld, 1'b0);
    tick();
    for (int k = 0; k < 6; k++) begin
      g = order[k];
      #1;
      chk("rr_aw_vld", m_aw_vld, 1'b1);
      chk("rr_aw_dat", m_aw_dat, mk_ax(rr_addr[g], 8'd0, 1'b0));
      chk("rr_aw_rdy", s_aw_rdy, 64'(1 << g));
      tick();
      #1;
      chk("rr_w_rdy", s_w_rdy, 64'(1 << g));
      chk("rr_w_dat", m_w_dat, mk_w(rr_wd[g]));
      tick();
      #1 chk("rr_b_vld", s_b_vld, 64'(1 << g));
      tick();
      if (k == 5) begin
        s_aw_vld = '0; s_w_vld = '0; s_w_last = '0; m_b_vld = 1'b0; s_b_rdy = '0;
      end
      #1 chk("rr_idle_gap", m_aw_vld, 1'b0);
      tick();
    end

    // Port 3: AW 0x40 len 3, four W beats, B OKAY on lane 3 only
    s_aw_vld[3] = 1'b1; s_aw_dat[3] = mk_ax(8'h40, 8'd3, 1'b1);
    #1 chk("p3_aw_not_yet", m_aw_vld, 1'b0);
    tick();
    #1;
    chk("p3_aw_vld", m_aw_vld, 1'b1);
    chk("p3_aw_dat", m_aw_dat, mk_ax(8'h40, 8'd3, 1'b1));
    chk("p3_aw_rdy", s_aw_rdy, 8'h08);
    tick();
    s_aw_vld = '0;
    for (int b = 0; b < 4; b++) begin
      s_w_vld[3] = 1'b1; s_w_dat[3] = mk_w(8'hB0 + 8'(b)); s_w_last[3] = (b == 3);
      #1;
      chk("p3_w_vld", m_w_vld, 1'b1);
      chk("p3_w_dat", m_w_dat, mk_w(8'hB0 + 8'(b)));
      chk("p3_w_last", m_w_last, 64'(b == 3));
      chk("p3_w_rdy", s_w_rdy, 8'h08);
      tick();
    end
    s_w_vld = '0; s_w_last = '0;
    m_b_vld = 1'b1; m_b_dat = 4'b1000; s_b_rdy[3] = 1'b1;
    #1;
    chk("p3_w_rdy_after_last", s_w_rdy, 8'h00);
    chk("p3_b_vld", s_b_vld, 8'h08);
    chk("p3_b_dat", s_b_dat[3], 4'b1000);
    chk("p3_b_rdy", m_b_rdy, 1'b1);
    tick();
    m_b_vld = 1'b0; s_b_rdy = '0;
    #1;
    chk("p3_idle_b_vld", s_b_vld, 8'h00);
    chk("p3_idle_aw_vld", m_aw_vld, 1'b0);

    // Port 2 read len 7 in parallel with port 5 single-beat write
    s_ar_vld[2] = 1'b1; s_ar_dat[2] = mk_ax(8'h20, 8'd7, 1'b0); s_r_rdy[2] = 1'b1;
    s_aw_vld[5] = 1'b1; s_aw_dat[5] = mk_ax(8'h50, 8'd0, 1'b1);
    s_w_vld[5] = 1'b1; s_w_dat[5] = mk_w(8'h55); s_w_last[5] = 1'b1; s_b_rdy[5] = 1'b1;
    m_ar_rdy = 1'b1;
    tick();
    #1;
    chk("cc_ar_vld", m_ar_vld, 1'b1);
    chk("cc_ar_dat", m_ar_dat, mk_ax(8'h20, 8'd7, 1'b0));
    chk("cc_ar_rdy", s_ar_rdy, 8'h04);
    chk("cc_aw_vld", m_aw_vld, 1'b1);
    chk("cc_aw_rdy", s_aw_rdy, 8'h20);
    tick();
    s_ar_vld = '0; s_aw_vld = '0;
    for (int b = 0; b < 8; b++) begin
      m_r_vld = 1'b1; m_r_dat = mk_r(8'hC0 + 8'(b)); m_r_last = (b == 7);
      if (b == 1) m_b_vld = 1'b1;
      if (b == 2) begin m_b_vld = 1'b0; s_w_vld = '0; end
      #1;
      chk("cc_r_vld", s_r_vld, 8'h04);
      chk("cc_r_dat", s_r_dat[2], mk_r(8'hC0 + 8'(b)));
      chk("cc_r_last", s_r_last[2], 64'(b == 7));
      chk("cc_r_rdy", m_r_rdy, 1'b1);
      if (b == 0) chk("cc_w_rdy", s_w_rdy, 8'h20);
      if (b == 1) begin
        chk("cc_b_vld", s_b_vld, 8'h20);
        chk("cc_single_beat", m_w_vld, 1'b0);
      end
      if (b == 2) chk("cc_b_done", s_b_vld, 8'h00);
      tick();
    end
    m_r_vld = 1'b0; m_r_last = 1'b0; s_b_rdy = '0; s_r_rdy = '0; s_w_last = '0;
    #1;
    chk("cc_r_idle", s_r_vld, 8'h00);
    chk("cc_r_rdy_idle", m_r_rdy, 1'b0);

    // Reset during beat 2 of a 4-beat read on port 4
    s_ar_vld[4] = 1'b1; s_ar_dat[4] = mk_ax(8'h48, 8'd3, 1'b0); s_r_rdy[4] = 1'b1;
    tick();
    #1 chk("rs_ar_rdy", s_ar_rdy, 8'h10);
    tick();
    s_ar_vld = '0;
    for (int b = 0; b < 2; b++) begin
      m_r_vld = 1'b1; m_r_dat = mk_r(8'hD0 + 8'(b));
      #1 chk("rs_r_vld", s_r_vld, 8'h10);
      tick();
    end
    m_r_dat = mk_r(8'hD2);
    #1 chk("rs_beat2_vld", s_r_vld, 8'h10);
    rst = 1'b1;
    #1;
    chk("rs_async_m_valids", {m_aw_vld, m_w_vld, m_ar_vld}, 3'b000);
    chk("rs_async_r_vld", s_r_vld, 8'h00);
    chk("rs_async_r_rdy", m_r_rdy, 1'b0);
    tick();
    rst = 1'b0; m_r_vld = 1'b0;
    s_ar_vld = 8'h21; s_r_rdy = 8'h21;
    s_ar_dat[0] = mk_ax(8'h0A, 8'd0, 1'b0); s_ar_dat[5] = mk_ax(8'h5A, 8'd0, 1'b1);
    tick();
    #1;
    chk("rs_prio_ar_dat", m_ar_dat, mk_ax(8'h0A, 8'd0, 1'b0));
    chk("rs_prio_ar_rdy", s_ar_rdy, 8'h01);
    tick();
    s_ar_vld = '0;
    m_r_vld = 1'b1; m_r_last = 1'b1; m_r_dat = mk_r(8'hE0);
    #1 chk("rs_p0_r_vld", s_r_vld, 8'h01);
    tick();
    m_r_vld = 1'b0; m_r_last = 1'b0; s_r_rdy = '0;
    #1 chk("rs_p0_r_done", s_r_vld, 8'h00);

    // Port 0 offers W before AW
    s_w_vld[0] = 1'b1; s_w_dat[0] = mk_w(8'h70); s_w_last[0] = 1'b0;
    #1;
    chk("wa_early_w_rdy", s_w_rdy, 8'h00);
    chk("wa_early_m_w_vld", m_w_vld, 1'b0);
    tick();
    s_aw_vld[0] = 1'b1; s_aw_dat[0] = mk_ax(8'h80, 8'd1, 1'b0);
    #1 chk("wa_idle_w_rdy", s_w_rdy, 8'h00);
    tick();
    m_aw_rdy = 1'b0;
    #1;
    chk("wa_addr_w_rdy", s_w_rdy, 8'h00);
    chk("wa_aw_stall_rdy", s_aw_rdy, 8'h00);
    tick();
    m_aw_rdy = 1'b1;
    #1;
    chk("wa_addr_hs_w_rdy", s_w_rdy, 8'h00);
    chk("wa_aw_rdy", s_aw_rdy, 8'h01);
    tick();
    s_aw_vld = '0;
    #1;
    chk("wa_w_rdy", s_w_rdy, 8'h01);
    chk("wa_w_dat0", m_w_dat, mk_w(8'h70));
    tick();
    s_w_dat[0] = mk_w(8'h71); s_w_last[0] = 1'b1;
    #1;
    chk("wa_w_dat1", m_w_dat, mk_w(8'h71));
    chk("wa_w_last1", m_w_last, 1'b1);
    tick();
    s_w_vld = '0; s_w_last = '0; m_b_vld = 1'b1; m_b_dat = 4'h0; s_b_rdy[0] = 1'b1;
    #1 chk("wa_b_vld", s_b_vld, 8'h01);
    tick();
    m_b_vld = 1'b0; s_b_rdy = '0;

    // PORT_EN = 8'h0F: port 7 never granted, port 0 still served
    s_aw_vld = 8'h81;
    s_aw_dat[7] = mk_ax(8'h77, 8'd0, 1'b1); s_aw_dat[0] = mk_ax(8'h0C, 8'd0, 1'b0);
    #1 chk("en_idle_aw_rdy7", e_s_aw_rdy[7], 1'b0);
    tick();
    #1;
    chk("en_aw_dat", e_m_aw_dat, mk_ax(8'h0C, 8'd0, 1'b0));
    chk("en_aw_rdy", e_s_aw_rdy, 8'h01);
    tick();
    s_aw_vld = 8'h80;
    s_w_vld[0] = 1'b1; s_w_last[0] = 1'b1; s_w_dat[0] = mk_w(8'h0D);
    #1 chk("en_w_rdy", e_s_w_rdy, 8'h01);
    tick();
    s_w_vld = '0; s_w_last = '0; m_b_vld = 1'b1; s_b_rdy[0] = 1'b1;
    #1 chk("en_b_vld", e_s_b_vld, 8'h01);
    tick();
    m_b_vld = 1'b0; s_b_rdy = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("en_p7_aw_vld", e_m_aw_vld, 1'b0);
      chk("en_p7_aw_rdy", e_s_aw_rdy, 8'h00);
      tick();
    end
    s_aw_vld = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
